jtag_uart_tx_arbiter: RTL and testbench
=======================================

# jtag_uart_tx_arbiter

- Shares the single JTAG UART transmit byte stream among `NUM_SRC` requesters, such as Pebbles cores or debug agents.
- Its output stream feeds the input stream of the JTAG UART Avalon bridge.
- Arbitration is round-robin and line-locked: a granted source owns the UART until it sends a newline, or until it stalls past a timeout.
- This keeps console lines from different sources from interleaving.

## Interface
- `NUM_SRC`, default 4: number of requesting byte streams (1..10).
- `TIMEOUT`, default 1024: number of consecutive idle cycles of the owner before forced release. 0 disables the timeout. Range is 16 bits.
- `clock`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high.
- `src_canGet`  in  NUM_SRC  source i has a byte available.
- `src_getData`  in  8*NUM_SRC  byte of source i, at bits [8i+7:8i].
- `src_get`  out  NUM_SRC  consume pulse to source i (one-hot or zero).
- `out_canGet`  out  1  output byte valid.
- `out_getData`  out  8  output byte.
- `out_get`  in  1  downstream consumes the output byte.
- `owner`  out  4  index of the current owner; valid when `locked`.
- `locked`  out  1  a source currently owns the stream.

## Operation
- **Output stage**: one-entry register `outFull`/`outData`.
  - `out_canGet = outFull`.
  - `slotFree = !outFull || out_get`, so a load and a drain in the same cycle are legal and give full throughput.
- **Round-robin pointer** `rrPtr`, range 0..NUM_SRC-1.
  - On release, `rrPtr` becomes owner+1, wrapping NUM_SRC-1 to 0.
- **States**:
  - **IDLE**: `locked=0`, `src_get=0`.
    - If any `src_canGet` is set, the grant goes to the first requester scanning from `rrPtr` upward with wrap.
    - Register `owner`, clear the timer, go to PREFIX_ID if the prefix macro is defined, else PASS.
  - **PREFIX_ID** (macro only): when `slotFree`, load ASCII `'0'+owner` (0x30+owner). Go to PREFIX_SEP.
  - **PREFIX_SEP** (macro only): when `slotFree`, load `':'` (0x3A). Go to PASS.
  - **PASS**: `src_get[owner] = src_canGet[owner] && slotFree`. This is combinational; no other bit may be set.
    - On a get: load `src_getData[owner]` and clear the timer.
    - If that byte is 0x0A, release and go to IDLE.
    - With no get and `!src_canGet[owner]`: increment the timer, saturating.
    - When `TIMEOUT != 0` and the timer reaches `TIMEOUT`, release and go to IDLE.
    - The timer does not advance while the owner has data but the output is back-pressured.
- **Non-owners**:
  - They never see `src_get`.
  - Their `canGet` changes are ignored until IDLE.
- **Reset values** (also applied on reset mid-line, with no partial flush):
  - `src_get=0`, `out_canGet=0`, `out_getData=0`.
  - `locked=0`, `owner=0`, `rrPtr=0`, timer=0, state IDLE.
  - Any buffered byte is dropped.
- **NUM_SRC=1**: same behaviour. The arbitration is trivial, and the pointer stays at 0.

## Timing
- Grant latency: request seen in IDLE in cycle 0 → state PASS in cycle 1 → `src_get` in cycle 1 → `out_canGet` in cycle 2.
- With prefix: ID byte valid in cycle 2, `':'` in cycle 3, first data byte in cycle 4 if downstream drains every cycle.
- Steady state: 1 byte/cycle while the owner supplies data and `out_get` is held high.
- Release costs one IDLE cycle before the next grant. A new owner's first byte is never loaded in the release cycle.
- `out_getData` holds stable while `out_canGet && !out_get`.

## Configuration
- `JTAG_UART_ARB_PREFIX_EN`:
  - **Defined**: every grant emits the two-byte prefix `'<id>:'` before the owner's data, and the PREFIX_ID/PREFIX_SEP states exist.
  - **Undefined**: the prefix states are absent and IDLE goes straight to PASS; the data stream is a pure concatenation of lines.

## Test plan
- **Single source, no contention**: src0 sends "hi\n" with `out_get` held at 1.
  - Output is "hi\n" (or "0:hi\n" with the prefix enabled).
  - The first byte is valid 2 cycles after the request (4 with the prefix).
  - Then `locked=0`.
- **Contention and wrap**: src1 and src3 both request "A\n"/"B\n" from reset.
  - src1 is served first, then src3.
  - src1 then re-requests and wins over src3's second line, because `rrPtr` wrapped to 0.
- **Line lock**: src0 sends "ab", stalls 10 cycles, then "\n", while src2 requests throughout (`TIMEOUT=1024`).
  - Output is "ab\n" with no src2 byte inside it.
  - src2 is granted only after the 0x0A.
- **Timeout**: `TIMEOUT=16`; src0 sends "x" then stops, and src1 requests.
  - Release occurs 16 idle cycles after the 'x'.
  - src1's data follows; src0 is not resumed until it is granted again.
- **Back-pressure**: `out_get` toggles 1,0,1,0 during a 4-byte line.
  - No byte is lost or duplicated.
  - `out_getData` is stable while not taken.
  - The timer does not advance.
- **Reset mid-line**: `reset` is pulsed for 1 cycle after 2 bytes of a 5-byte line.
  - The next cycle shows `out_canGet=0`, `locked=0`, `src_get=0`.
  - The subsequent grant starts again from src0 per `rrPtr=0`.

Source files
------------

// File: rtl/jtag_uart_tx_arbiter.sv
// Round-robin, line-locked arbiter sharing one JTAG UART transmit byte stream among NUM_SRC sources.
// Optional `JTAG_UART_ARB_PREFIX_EN: each grant emits "<id>:" ahead of the owner's data.
module jtag_uart_tx_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SRC-1:0]     src_canGet,
    input  logic [8*NUM_SRC-1:0]   src_getData,
    output logic [NUM_SRC-1:0]     src_get,
    output logic                   out_canGet,
    output logic [7:0]             out_getData,
    input  logic                   out_get,
    output logic [3:0]             owner,
    output logic                   locked
);

`ifdef JTAG_UART_ARB_PREFIX_EN
    typedef enum logic [1:0] {IDLE, PREFIX_ID, PREFIX_SEP, PASS} state_t;
`else
    typedef enum logic [0:0] {IDLE, PASS} state_t;
`endif

    state_t      state, state_next;
    logic [3:0]  owner_next;
    logic [3:0]  rr_ptr, rr_ptr_next;
    logic [15:0] timer, timer_next, timer_inc;
    logic        out_full;
    logic [7:0]  out_data;
    logic        slot_free;
    logic        load;
    logic [7:0]  load_data;
    logic        line_done;
    logic        found;
    logic [3:0]  grant;
    logic        sel_can;
    logic [7:0]  sel_data;
    logic        take;

    assign slot_free   = !out_full || out_get;
    assign out_canGet  = out_full;
    assign out_getData = out_data;
    assign locked      = (state != IDLE);

    always_comb begin
        state_next  = state;
        owner_next  = owner;
        rr_ptr_next = rr_ptr;
        timer_next  = timer;
        src_get     = '0;
        load        = 1'b0;
        load_data   = '0;
        line_done   = 1'b0;
        found       = 1'b0;
        grant       = '0;
        sel_can     = 1'b0;
        sel_data    = '0;
        take        = 1'b0;
        timer_inc   = (timer == '1) ? timer : timer + 16'd1;

        // Two passes give the first requester at or above rr_ptr, else the lowest one (wrap).
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            if (!found && src_canGet[j] && (4'(j) >= rr_ptr)) begin
                found = 1'b1;
                grant = 4'(j);
            end
        end
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            if (!found && src_canGet[j]) begin
                found = 1'b1;
                grant = 4'(j);
            end
        end

        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            if (owner == 4'(j)) begin
                sel_can  = src_canGet[j];
                sel_data = src_getData[8*j +: 8];
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    owner_next = grant;
                    timer_next = '0;
`ifdef JTAG_UART_ARB_PREFIX_EN
                    state_next = PREFIX_ID;
`else
                    state_next = PASS;
`endif
                end
            end
`ifdef JTAG_UART_ARB_PREFIX_EN
            PREFIX_ID: begin
                if (slot_free) begin
                    load       = 1'b1;
                    load_data  = 8'h30 + {4'h0, owner};
                    state_next = PREFIX_SEP;
                end
            end
            PREFIX_SEP: begin
                if (slot_free) begin
                    load       = 1'b1;
                    load_data  = 8'h3A;
                    state_next = PASS;
                end
            end
`endif
            PASS: begin
                take = sel_can && slot_free;
                if (take) begin
                    load       = 1'b1;
                    load_data  = sel_data;
                    timer_next = '0;
                    line_done  = (sel_data == 8'h0A);
                end else if (!sel_can) begin
                    timer_next = timer_inc;
                    line_done  = (TIMEOUT != 0) && (timer_inc == 16'(TIMEOUT));
                end
                if (line_done) begin
                    state_next  = IDLE;
                    rr_ptr_next = (owner == 4'(NUM_SRC - 1)) ? '0 : owner + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            src_get[j] = take && (owner == 4'(j));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            timer    <= '0;
            out_full <= 1'b0;
            out_data <= '0;
        end else begin
            state  <= state_next;
            owner  <= owner_next;
            rr_ptr <= rr_ptr_next;
            timer  <= timer_next;
            if (load) begin
                out_full <= 1'b1;
                out_data <= load_data;
            end else if (out_get) begin
                out_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtag_uart_tx_arbiter.sv
// Directed bench for jtag_uart_tx_arbiter: source byte queues feed the DUT, expected output bytes
// are queued in arbitration order and compared as the downstream consumes them.
module tb_jtag_uart_tx_arbiter;
    localparam int unsigned NSRC = 4;
    localparam int unsigned TMO  = 16;
`ifdef JTAG_UART_ARB_PREFIX_EN
    localparam int unsigned PFX = 2;
`else
    localparam int unsigned PFX = 0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic [NSRC-1:0]   src_canGet;
    logic [8*NSRC-1:0] src_getData;
    logic [NSRC-1:0]   src_get;
    logic              out_canGet;
    logic [7:0]        out_getData;
    logic              out_get;
    logic [3:0]        owner;
    logic              locked;

    always #5 clock = ~clock;

    jtag_uart_tx_arbiter #(.NUM_SRC(NSRC), .TIMEOUT(TMO)) dut (
        .clock       (clock),
        .reset       (reset),
        .src_canGet  (src_canGet),
        .src_getData (src_getData),
        .src_get     (src_get),
        .out_canGet  (out_canGet),
        .out_getData (out_getData),
        .out_get     (out_get),
        .owner       (owner),
        .locked      (locked)
    );

    logic [7:0]  srcq [NSRC][$];
    logic [NSRC-1:0] hold;
    logic [7:0]  exp_q [$];
    int unsigned byte_cyc [$];
    int unsigned get_cyc [NSRC];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned out_count = 0;
    logic        s_locked;
    int unsigned s_cyc;
    logic        prev_wait;
    logic [7:0]  prev_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NSRC; i++) begin
            src_canGet[i] = !hold[i] && (srcq[i].size() > 0);
            src_getData[8*i +: 8] = (srcq[i].size() > 0) ? srcq[i][0] : 8'h00;
        end
    endtask

    // One clock: sample at the falling edge, then pop consumed source bytes just after the rising edge.
    task automatic tick();
        logic [NSRC-1:0] g;
        drive();
        @(negedge clock);
        s_locked = locked;
        s_cyc    = cyc;
        g        = src_get;
        check("src_get_onehot0", 32'($onehot0(src_get)), 32'd1);
        check("src_get_without_data", 32'(src_get & ~src_canGet), 32'd0);
        if (prev_wait) begin
            check("hold_valid", 32'(out_canGet), 32'd1);
            check("hold_data", 32'(out_getData), 32'(prev_data));
        end
        prev_wait = out_canGet && !out_get && !reset;
        prev_data = out_getData;
        if (out_canGet && out_get && !reset) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL extra_byte: observed %0h expected no byte", out_getData);
            end
            if (exp_q.size() != 0) check("out_byte", 32'(out_getData), 32'(exp_q.pop_front()));
            byte_cyc.push_back(cyc);
            out_count++;
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < NSRC; i++) begin
            if (g[i]) begin
                get_cyc[i] = cyc;
                if (srcq[i].size() > 0) srcq[i].delete(0);
            end
        end
        cyc++;
        drive();
    endtask

    task automatic load(input int s, input string str);
        for (int k = 0; k < str.len(); k++) srcq[s].push_back(str[k]);
    endtask

    task automatic expect_line(input int s, input string str);
        if (PFX != 0) begin
            exp_q.push_back(8'(32'h30 + s));
            exp_q.push_back(8'h3A);
        end
        for (int k = 0; k < str.len(); k++) exp_q.push_back(str[k]);
    endtask

    task automatic wait_count(input int unsigned target, input int unsigned budget, input string tag);
        int unsigned n = 0;
        while (out_count < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(out_count >= target), 32'd1);
    endtask

    task automatic wait_drain(input int unsigned budget, input string tag);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_owner(input logic [3:0] o, input int unsigned budget, input string tag);
        int unsigned n = 0;
        while (!(locked && owner == o) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(locked && owner == o), 32'd1);
    endtask

    initial begin
        int unsigned c0, base, gx, n;
        reset       = 1'b1;
        out_get     = 1'b1;
        hold        = '0;
        src_canGet  = '0;
        src_getData = '0;
        prev_wait   = 1'b0;
        prev_data   = '0;
        for (int i = 0; i < NSRC; i++) get_cyc[i] = 0;

        repeat (3) tick();
        check("reset_out_canGet", 32'(out_canGet), 32'd0);
        check("reset_out_getData", 32'(out_getData), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_owner", 32'(owner), 32'd0);
        check("reset_src_get", 32'(src_get), 32'd0);
        reset = 1'b0;
        tick();

        // Single source, no contention: first byte two cycles after the request.
        c0   = cyc;
        base = out_count;
        load(0, "hi\n");
        expect_line(0, "hi\n");
        wait_drain(20, "t1_drain");
        check("t1_first_data_cycle", byte_cyc[base + PFX], c0 + 2 + PFX);
        check("t1_first_byte_cycle", byte_cyc[base], c0 + 2);
        tick();
        check("t1_unlocked", 32'(locked), 32'd0);

        // Contention: src1 then src3; src1 re-requests and beats src3's second line.
        load(1, "A\n");
        load(3, "B\nD\n");
        expect_line(1, "A\n");
        expect_line(3, "B\n");
        expect_line(1, "C\n");
        expect_line(3, "D\n");
        wait_owner(4'd3, 30, "t2_owner3");
        load(1, "C\n");
        wait_drain(60, "t2_drain");

        // Line lock: src0 stalls mid-line below the timeout while src2 keeps requesting.
        load(0, "ab");
        load(2, "Z\n");
        expect_line(0, "ab\n");
        expect_line(2, "Z\n");
        base = out_count;
        wait_count(base + PFX + 2, 20, "t3_ab");
        repeat (10) tick();
        check("t3_still_owner0", 32'(locked && owner == 4'd0), 32'd1);
        load(0, "\n");
        wait_drain(30, "t3_drain");

        // Timeout: src0 sends 'x' and goes quiet; release after exactly TMO idle cycles.
        load(0, "x");
        expect_line(0, "x");
        expect_line(1, "Y\n");
        expect_line(0, "w\n");
        wait_owner(4'd0, 10, "t4_owner0");
        load(1, "Y\n");
        n = 0;
        while (srcq[0].size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("t4_x_taken", 32'(srcq[0].size()), 32'd0);
        gx = get_cyc[0];
        n  = 0;
        s_locked = 1'b1;
        while (s_locked && n < 40) begin
            tick();
            n++;
        end
        check("t4_release_cycle", s_cyc, gx + TMO + 1);
        wait_owner(4'd1, 10, "t4_owner1");
        load(0, "w\n");
        wait_drain(40, "t4_drain");

        // Back-pressure: alternating out_get, then a long stall longer than the timeout.
        load(1, "pqr\n");
        expect_line(1, "pqr\n");
        for (int k = 0; k < 6; k++) begin
            out_get = (k % 2 == 0);
            tick();
        end
        out_get = 1'b0;
        repeat (20) tick();
        check("t5_locked_owner1", 32'(locked && owner == 4'd1), 32'd1);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            out_get = (k % 2 == 0);
            tick();
        end
        out_get = 1'b1;
        check("t5_drain", 32'(exp_q.size()), 32'd0);

        // Reset mid-line, with rr pointer at 2 beforehand.
        load(3, "abcd\n");
        expect_line(3, "abcd\n");
        base = out_count;
        wait_count(base + PFX + 2, 20, "t6_two_bytes");
        out_get = 1'b0;
        hold[3] = 1'b1;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_out_canGet", 32'(out_canGet), 32'd0);
        check("t6_out_getData", 32'(out_getData), 32'd0);
        check("t6_locked", 32'(locked), 32'd0);
        check("t6_src_get", 32'(src_get), 32'd0);
        check("t6_owner", 32'(owner), 32'd0);
        srcq[3].delete();
        exp_q.delete();
        hold[3] = 1'b0;
        out_get = 1'b1;
        load(0, "P\n");
        load(3, "Q\n");
        expect_line(0, "P\n");
        expect_line(3, "Q\n");
        wait_drain(40, "t6_drain");

        repeat (3) tick();
        check("final_unlocked", 32'(locked), 32'd0);
        check("final_out_empty", 32'(out_canGet), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
